data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 169 ++++++++++++++++
 tb/tb_data_ram.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram
//  Description : Byte-addressable 32-bit data memory for a RISC-style CPU.
//                It supports byte, half and word loads and stores with sign
//                or zero extension, and has a registered read port with
//                read-before-write behaviour. A sticky fault flag records the
//                address of the first illegal or out-of-range access.
//  Revision    : 1.0  initial release
// ============================================================================
module data_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_ram_addr,
    input  logic [31:0] i_ram_wdata,
    input  logic        i_ram_we,
    input  logic [2:0]  i_ram_mode,
    output logic [31:0] o_ram_rdata,
    output logic        o_fault,
    output logic [31:0] o_fault_addr
);

    localparam int          AW           = $clog2(DEPTH_WORDS);
    // Comparison is done at 33 bits so that a 4 GiB array cannot overflow the limit.
    localparam logic [32:0] c_BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [0:0] {
        CLEAN   = 1'b0,
        FAULTED = 1'b1
    } fault_state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic [31:0]   r_fault_addr;
    fault_state_t  r_state;
    fault_state_t  w_state_nxt;
    logic          w_capture;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_mode_illegal;
    logic          w_misalign;
    logic          w_oob;
    logic          w_fault;
    logic          w_fault_evt;
    logic          w_wr_en;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    assign w_idx  = i_ram_addr[AW+1:2];
    assign w_lane = i_ram_addr[1:0];

    // Access checks: mode legality, natural alignment and address range.
    assign w_mode_illegal = (i_ram_mode == 3'b011) || (i_ram_mode[2:1] == 2'b11);
    assign w_misalign     = ((i_ram_mode[1:0] == 2'b01) && i_ram_addr[0])
                         || ((i_ram_mode[1:0] == 2'b10) && (i_ram_addr[1:0] != 2'b00));
    assign w_oob          = ({1'b0, i_ram_addr} >= c_BYTE_LIMIT);
    assign w_fault        = w_mode_illegal || w_misalign || w_oob;
    // Mode 011 without a write is how the CPU signals an idle cycle.
    assign w_fault_evt    = w_fault && !((i_ram_mode == 3'b011) && !i_ram_we);
    // A store is blocked as a whole while reset is asserted, never partially.
    assign w_wr_en        = i_ram_we && !w_fault && !rst;

    // Byte-lane enables and lane-replicated store data; unsigned store modes alias signed ones.
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = i_ram_wdata;
        case (i_ram_mode[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{i_ram_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = i_ram_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{i_ram_wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b1111;
            end
            default: begin
                w_be        = 4'b0000;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the pre-write word.
    always_comb begin
        w_word = r_mem[w_idx];
        w_byte = w_word[8*w_lane +: 8];
        w_half = i_ram_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load = 32'd0;
        case (i_ram_mode)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
        if (w_fault) begin
            w_load = 32'd0;
        end
    end

    // Storage: byte-lane writes with no reset, so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Registered load data, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else begin
            r_rdata <= w_load;
        end
    end

    // Fault FSM state register and first-fault address capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= CLEAN;
            r_fault_addr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_fault_addr <= i_ram_addr;
            end
        end
    end

    // Fault FSM next state: the first fault latches until reset.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            CLEAN: begin
                if (w_fault_evt) begin
                    w_state_nxt = FAULTED;
                    w_capture   = 1'b1;
                end
            end
            FAULTED: begin
                w_state_nxt = FAULTED;
            end
            default: begin
                w_state_nxt = CLEAN;
            end
        endcase
    end

    assign o_ram_rdata  = r_rdata;
    assign o_fault      = (r_state == FAULTED);
    assign o_fault_addr = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_ram
//  Description : Self-checking bench for data_ram with a byte-array reference
//                model, directed scenarios and randomized accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_ram;

    localparam int DEPTH = 64;
    localparam int NBYTE = 4 * DEPTH;

    logic        clk;
    logic        rst;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [2:0]  r_mode;
    logic [31:0] w_rdata;
    logic        w_fault;
    logic [31:0] w_fault_addr;

    int n_vec;
    int n_err;

    // Reference state: byte array plus sticky fault record.
    logic [7:0]  m_mem [NBYTE];
    logic        m_fault;
    logic [31:0] m_faddr;

    data_ram #(.DEPTH_WORDS(DEPTH)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_ram_addr   (r_addr),
        .i_ram_wdata  (r_wdata),
        .i_ram_we     (r_we),
        .i_ram_mode   (r_mode),
        .o_ram_rdata  (w_rdata),
        .o_fault      (w_fault),
        .o_fault_addr (w_fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit mode_illegal(input logic [2:0] md);
        return (md == 3'd3) || (md == 3'd6) || (md == 3'd7);
    endfunction

    function automatic int acc_size(input logic [2:0] md);
        return 1 << md[1:0];
    endfunction

    function automatic bit is_fault(input logic [31:0] a, input logic we, input logic [2:0] md);
        if (md == 3'd3 && !we) return 1'b0;
        if (mode_illegal(md)) return 1'b1;
        if ((a % acc_size(md)) != 0) return 1'b1;
        if (a >= 32'(NBYTE)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] md);
        logic [31:0] v;
        int sz;
        if (mode_illegal(md) || is_fault(a, 1'b0, md)) return 32'd0;
        sz = acc_size(md);
        v  = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(m_mem[int'(a) + i]) << (8 * i));
        if (!md[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    // One access cycle: drive at negedge, predict, check just after posedge.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [2:0] md, input bit check_rd);
        logic [31:0] exp_rd;
        bit          flt;
        @(negedge clk);
        r_addr = a; r_wdata = wd; r_we = we; r_mode = md;
        exp_rd = model_load(a, md);
        flt    = is_fault(a, we, md);
        if (flt && !m_fault) begin
            m_fault = 1'b1;
            m_faddr = a;
        end
        if (we && !flt) begin
            for (int i = 0; i < acc_size(md); i++) m_mem[int'(a) + i] = wd[8*i +: 8];
        end
        @(posedge clk);
        #1;
        if (check_rd) chk("rdata", w_rdata, exp_rd);
        chk("fault", {31'd0, w_fault}, {31'd0, m_fault});
        chk("fault_addr", w_fault_addr, m_faddr);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  md;
        logic [2:0]  legal_modes [5];
        n_vec = 0; n_err = 0;
        m_fault = 1'b0; m_faddr = 32'd0;
        legal_modes[0] = 3'd0; legal_modes[1] = 3'd1; legal_modes[2] = 3'd2;
        legal_modes[3] = 3'd4; legal_modes[4] = 3'd5;
        rst = 1'b0; r_addr = 32'd0; r_wdata = 32'd0; r_we = 1'b0; r_mode = 3'd2;

        // Asynchronous power-on reset.
        #2 rst = 1'b1;
        #1;
        chk("rst_rdata", w_rdata, 32'd0);
        chk("rst_fault", {31'd0, w_fault}, 32'd0);
        chk("rst_faddr", w_fault_addr, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Fill memory with known random words so every read is predictable.
        for (int w = 0; w < DEPTH; w++) step(32'(4 * w), $urandom, 1'b1, 3'd2, 1'b0);

        // Word store and load.
        step(32'h10, 32'hDEADBEEF, 1'b1, 3'd2, 1'b1);
        step(32'h10, 32'd0, 1'b0, 3'd2, 1'b1);
        chk("word_ld", w_rdata, 32'hDEADBEEF);

        // Byte store with signed/unsigned reload.
        step(32'h10, 32'd0, 1'b1, 3'd2, 1'b1);
        step(32'h13, 32'h80, 1'b1, 3'd0, 1'b1);
        step(32'h13, 32'd0, 1'b0, 3'd0, 1'b1);
        chk("lb_sign", w_rdata, 32'hFFFFFF80);
        step(32'h13, 32'd0, 1'b0, 3'd4, 1'b1);
        chk("lbu_zero", w_rdata, 32'h00000080);
        step(32'h10, 32'd0, 1'b0, 3'd2, 1'b1);
        chk("lb_word", w_rdata, 32'h80000000);

        // Upper half store.
        step(32'h20, 32'd0, 1'b1, 3'd2, 1'b1);
        step(32'h22, 32'h1234, 1'b1, 3'd1, 1'b1);
        step(32'h22, 32'd0, 1'b0, 3'd1, 1'b1);
        chk("lh", w_rdata, 32'h00001234);
        step(32'h20, 32'd0, 1'b0, 3'd2, 1'b1);
        chk("lh_word", w_rdata, 32'h12340000);

        // Read-before-write on the same address.
        step(32'h40, 32'h55555555, 1'b1, 3'd2, 1'b1);
        step(32'h40, 32'hAAAAAAAA, 1'b1, 3'd2, 1'b1);
        chk("rbw_old", w_rdata, 32'h55555555);
        step(32'h40, 32'd0, 1'b0, 3'd2, 1'b1);
        chk("rbw_new", w_rdata, 32'hAAAAAAAA);

        // Random legal, aligned, in-range traffic (loads and stores mixed).
        for (int k = 0; k < 300; k++) begin
            md = legal_modes[$urandom_range(0, 4)];
            a  = 32'($urandom_range(0, NBYTE - 1)) & ~32'(acc_size(md) - 1);
            step(a, $urandom, 1'($urandom_range(0, 1)), md, 1'b1);
        end
        chk("no_fault_yet", {31'd0, w_fault}, 32'd0);

        // Misaligned word store faults and leaves memory untouched.
        step(32'h06, 32'hCAFEF00D, 1'b1, 3'd2, 1'b1);
        chk("mis_fault", {31'd0, w_fault}, 32'd1);
        chk("mis_faddr", w_fault_addr, 32'h6);
        step(32'h04, 32'd0, 1'b0, 3'd2, 1'b1);
        step(32'h4000, 32'd0, 1'b0, 3'd2, 1'b1);
        chk("oob_rdata", w_rdata, 32'd0);
        chk("faddr_held", w_fault_addr, 32'h6);

        // Random traffic including illegal modes, misalignment and out-of-range.
        for (int k = 0; k < 200; k++) begin
            md = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NBYTE - 1));
            step(a, $urandom, 1'($urandom_range(0, 1)), md, 1'b1);
        end

        // Asynchronous reset between edges while faulted; a store during reset is blocked.
        @(negedge clk);
        r_addr = 32'h40; r_wdata = 32'h12345678; r_we = 1'b1; r_mode = 3'd2;
        #2 rst = 1'b1;
        #1;
        chk("arst_fault", {31'd0, w_fault}, 32'd0);
        chk("arst_rdata", w_rdata, 32'd0);
        chk("arst_faddr", w_fault_addr, 32'd0);
        m_fault = 1'b0; m_faddr = 32'd0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        r_we = 1'b0;
        step(32'h40, 32'd0, 1'b0, 3'd2, 1'b1);
        step(32'h10, 32'd0, 1'b0, 3'd2, 1'b1);

        // Mode 011 without write is idle; mode 110 load faults.
        step(32'h9, 32'd0, 1'b0, 3'd3, 1'b1);
        chk("idle_nofault", {31'd0, w_fault}, 32'd0);
        step(32'h24, 32'd0, 1'b0, 3'd6, 1'b1);
        chk("ill_fault", {31'd0, w_fault}, 32'd1);
        chk("ill_faddr", w_fault_addr, 32'h24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
